// File: rtl/imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// imm_ext_arbiter
//
// Shares one registered sign-extender (SIZE_IN -> SIZE_OUT, one-clock latency)
// between two immediate requesters. Requesters are arbitrated round-robin. The
// winning operand is held on the extender input while the extender's latency
// elapses. The result then goes back to the winner, with an optional
// zero-extend override. Completed transactions are counted.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   reqN_valid/imm/zext/ready      requester N operand handshake (N = 0, 1)
//   respN_valid/ready              requester N result handshake
//   resp_data                      result shared by both requesters (0 outside RESP)
//   ext_valin                      drives the extender input (always op_q)
//   ext_extended                   extender registered output
//   done_count                     completed transactions, wraps at 16 bits
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | arbitrate; accept one operand into op_q
// EXT   | extender samples op_q at the closing edge
// RESP  | present result to owner; leave when the owner takes it
// -----------------------------------------------------------------------------
module imm_ext_arbiter #(
  parameter int SIZE_IN  = 10,
  parameter int SIZE_OUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [SIZE_IN-1:0]  req0_imm,
  input  logic                req0_zext,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SIZE_IN-1:0]  req1_imm,
  input  logic                req1_zext,
  output logic                req1_ready,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [SIZE_OUT-1:0] resp_data,
  output logic [SIZE_IN-1:0]  ext_valin,
  input  logic [SIZE_OUT-1:0] ext_extended,
  output logic [15:0]         done_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SIZE_IN-1:0] op_q, op_d;
  logic               zext_q, zext_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [15:0]        done_count_q, done_count_d;

  logic grant0;
  logic grant1;
  logic owner_resp_ready;

  // A lone requester always wins. On a tie, the one not granted last wins.
  // last_grant_q resets to 1 so requester 0 takes the first tie.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  // Only the owner's resp_ready can close a transaction.
  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    zext_d       = zext_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    done_count_d = done_count_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    resp_data    = '0;

    case (state_q)
      ST_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0) begin
          op_d         = req0_imm;
          zext_d       = req0_zext;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXT;
        end else if (grant1) begin
          op_d         = req1_imm;
          zext_d       = req1_zext;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXT;
        end
      end

      ST_EXT: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        // Zero-extend override: keep only the raw immediate bits of the result.
        resp_data   = zext_q ? {{(SIZE_OUT-SIZE_IN){1'b0}}, ext_extended[SIZE_IN-1:0]}
                             : ext_extended;
        if (owner_resp_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      zext_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      done_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      zext_q       <= zext_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      done_count_q <= done_count_d;
    end
  end

  // op_q only changes on accept, so the extender input is stable through EXT and RESP.
  assign ext_valin  = op_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_arbiter
//
// Bench for imm_ext_arbiter. It contains a stand-in for the registered
// extender. A driver takes operands from per-requester stimulus queues. When
// the DUT accepts an operand, the driver pushes that operand's expected result
// into a per-requester scoreboard queue. A negedge monitor follows a
// transaction-level model and compares every cycle. It checks arbitration
// fairness, the 2-cycle response latency, idle outputs, ext_valin and
// done_count. It pops the scoreboard when the owner takes a result.
// -----------------------------------------------------------------------------
module tb_imm_ext_arbiter;

  typedef struct {
    logic [9:0]  imm;
    logic        zext;
    logic [31:0] expv;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0]  req0_imm = '0, req1_imm = '0;
  logic        req0_zext = 1'b0, req1_zext = 1'b0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp_data;
  logic [9:0]  ext_valin;
  logic [31:0] ext_extended = '0;
  logic [15:0] done_count;

  item_t       stim0[$], stim1[$];
  logic [31:0] exp0[$], exp1[$];
  item_t       cur0, cur1;
  int          rr_mode0 = 1, rr_mode1 = 1;   // 0 low, 1 high, 2 random
  bit          gaps_en = 1'b0, wd_en = 1'b0;
  int          n_issued = 0, n_done = 0, n_dropped = 0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          done_log[$], acc_log[$], own_log[$];

  // monitor model state
  int          m_phase = 0;
  logic        m_own = 1'b0, m_last = 1'b1, m_armed = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [9:0]  m_op = '0;

  imm_ext_arbiter #(.SIZE_IN(10), .SIZE_OUT(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_imm     (req0_imm),
    .req0_zext    (req0_zext),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_imm     (req1_imm),
    .req1_zext    (req1_zext),
    .req1_ready   (req1_ready),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp_data    (resp_data),
    .ext_valin    (ext_valin),
    .ext_extended (ext_extended),
    .done_count   (done_count)
  );

  always #5 clk = ~clk;

  // Registered sign-extender stand-in, one clock of latency.
  always @(posedge clk) ext_extended <= {{22{ext_valin[9]}}, ext_valin};

  // Reference: the immediate's value as a signed (or unsigned) integer, in 32 bits.
  function automatic logic [31:0] ref_ext(input logic [9:0] imm, input logic zext);
    int v;
    v = int'(imm);
    if (!zext && v >= 512) v = v - 1024;
    return 32'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input int n, input logic [9:0] imm, input logic zext,
                      input logic [31:0] expv);
    item_t it;
    it.imm  = imm;
    it.zext = zext;
    it.expv = expv;
    if (n == 0) stim0.push_back(it);
    else        stim1.push_back(it);
    n_issued++;
  endtask

  task automatic wait_all(input string nm, input int budget);
    int k;
    k = 0;
    while ((n_done + n_dropped) < n_issued && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(n_done + n_dropped), 32'(n_issued));
  endtask

  task automatic wait_resp0(input string nm);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp0_valid) break;
    end
    chk(nm, 32'(resp0_valid), 32'd1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Driver: the only process that drives requester-side inputs.
  initial begin : driver
    logic hs0, hs1;
    int   gap0, gap1;
    gap0 = 0;
    gap1 = 0;
    forever begin
      @(negedge clk);
      hs0 = req0_valid & req0_ready & ~rst;
      hs1 = req1_valid & req1_ready & ~rst;
      if (hs0) exp0.push_back(cur0.expv);
      if (hs1) exp1.push_back(cur1.expv);
      @(posedge clk); #1;
      if (hs0) begin
        req0_valid = 1'b0;
        gap0 = gaps_en ? int'($urandom_range(0, 3)) : 0;
      end else if (req0_valid && wd_en && $urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
        n_dropped++;
      end
      if (!req0_valid) begin
        if (gap0 > 0) gap0--;
        else if (stim0.size() > 0) begin
          cur0 = stim0.pop_front();
          req0_valid = 1'b1; req0_imm = cur0.imm; req0_zext = cur0.zext;
        end
      end
      if (hs1) begin
        req1_valid = 1'b0;
        gap1 = gaps_en ? int'($urandom_range(0, 3)) : 0;
      end else if (req1_valid && wd_en && $urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
        n_dropped++;
      end
      if (!req1_valid) begin
        if (gap1 > 0) gap1--;
        else if (stim1.size() > 0) begin
          cur1 = stim1.pop_front();
          req1_valid = 1'b1; req1_imm = cur1.imm; req1_zext = cur1.zext;
        end
      end
      resp0_ready = (rr_mode0 == 2) ? ($urandom_range(0, 2) != 0) : (rr_mode0 == 1);
      resp1_ready = (rr_mode1 == 2) ? ($urandom_range(0, 2) != 0) : (rr_mode1 == 1);
    end
  end

  // Monitor: transaction-level model, compared every cycle.
  initial begin : monitor
    logic        w_any, w;
    logic [31:0] expd;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_phase = 0; m_last = 1'b1; m_cnt = '0; m_op = '0; m_own = 1'b0; m_armed = 1'b1;
        exp0.delete(); exp1.delete();
      end else if (m_armed) begin
        chk("done_count", 32'(done_count), 32'(m_cnt));
        chk("ext_valin", 32'(ext_valin), 32'(m_op));
        if (m_phase == 0) begin
          chk("resp_valid_idle", 32'({resp1_valid, resp0_valid}), 32'd0);
          chk("resp_data_idle", resp_data, 32'd0);
          w_any = req0_valid | req1_valid;
          w     = (req0_valid & req1_valid) ? ~m_last : req1_valid;
          chk("grant", 32'({req1_ready, req0_ready}),
              w_any ? (w ? 32'd2 : 32'd1) : 32'd0);
          if (w_any) begin
            m_own = w; m_last = w; m_op = w ? req1_imm : req0_imm; m_phase = 1;
            acc_log.push_back(cyc); own_log.push_back(int'(w));
          end
        end else if (m_phase == 1) begin
          chk("ready_ext", 32'({req1_ready, req0_ready}), 32'd0);
          chk("resp_valid_ext", 32'({resp1_valid, resp0_valid}), 32'd0);
          chk("resp_data_ext", resp_data, 32'd0);
          m_phase = 2;
        end else begin
          chk("ready_resp", 32'({req1_ready, req0_ready}), 32'd0);
          chk("resp_valid", 32'({resp1_valid, resp0_valid}), m_own ? 32'd2 : 32'd1);
          if ((m_own ? exp1.size() : exp0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL resp_scoreboard: response for requester %0d with no expected entry", m_own);
          end else begin
            expd = m_own ? exp1[0] : exp0[0];
            chk("resp_data", resp_data, expd);
          end
          if (m_own ? resp1_ready : resp0_ready) begin
            if (m_own && exp1.size() > 0) expd = exp1.pop_front();
            if (!m_own && exp0.size() > 0) expd = exp0.pop_front();
            m_cnt++; n_done++; done_log.push_back(cyc); m_phase = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: cycle budget exhausted, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // sign-extend, single requester
    @(negedge clk);
    push(0, 10'h3FF, 1'b0, 32'hFFFF_FFFF);
    wait_all("t1_done", 50);
    @(negedge clk);
    chk("t1_count", 32'(done_count), 32'd1);
    chk("t1_latency", 32'(done_log[done_log.size()-1] - acc_log[acc_log.size()-1]), 32'd2);

    // zero-extend and positive/negative boundaries
    push(1, 10'h3FF, 1'b1, 32'h0000_03FF);
    push(1, 10'h1FF, 1'b0, 32'h0000_01FF);
    push(1, 10'h200, 1'b0, 32'hFFFF_FE00);
    wait_all("t2_done", 100);

    // contention from reset: strict alternation, one result per 3 cycles
    pulse_rst();
    @(negedge clk);
    acc_log.delete(); own_log.delete(); done_log.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 10'h001, 1'b0, 32'h0000_0001);
      push(1, 10'h3FE, 1'b0, 32'hFFFF_FFFE);
    end
    wait_all("t3_done", 100);
    for (int i = 0; i < 6; i++) chk("t3_grant_order", 32'(own_log[i]), 32'(i % 2));
    for (int i = 1; i < 6; i++) chk("t3_spacing", 32'(done_log[i] - done_log[i-1]), 32'd3);

    // backpressure on requester 0 while requester 1 waits
    rr_mode0 = 0;
    push(0, 10'h155, 1'b0, 32'h0000_0155);
    wait_resp0("t4_resp0_seen");
    push(1, 10'h0AA, 1'b1, 32'h0000_00AA);
    repeat (5) @(negedge clk);
    rr_mode0 = 1;
    wait_all("t4_done", 100);
    chk("t4_next_owner", 32'(own_log[own_log.size()-1]), 32'd1);
    chk("t4_regrant_gap",
        32'(acc_log[acc_log.size()-1] - done_log[done_log.size()-2]), 32'd1);

    // reset while in EXT
    @(negedge clk);
    push(0, 10'h2AB, 1'b0, ref_ext(10'h2AB, 1'b0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req0_valid & req0_ready) break;
    end
    chk("t5_accept_seen", 32'(req0_valid & req0_ready), 32'd1);
    pulse_rst();
    n_dropped++;
    repeat (4) @(negedge clk);
    chk("t5_count_cleared", 32'(done_count), 32'd0);
    chk("t5_data_cleared", resp_data, 32'd0);
    push(0, 10'h0F0, 1'b1, 32'h0000_00F0);
    push(1, 10'h30F, 1'b0, 32'hFFFF_FF0F);
    wait_all("t5_done", 100);
    chk("t5_tie_owner", 32'(own_log[own_log.size()-2]), 32'd0);

    // reset while in RESP, coinciding with the owner's resp_ready
    rr_mode0 = 0;
    push(0, 10'h300, 1'b1, 32'h0000_0300);
    wait_resp0("t6_resp0_seen");
    rr_mode0 = 1;
    pulse_rst();
    n_dropped++;
    repeat (4) @(negedge clk);
    chk("t6_count_cleared", 32'(done_count), 32'd0);
    chk("t6_no_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
    push(1, 10'h011, 1'b0, 32'h0000_0011);
    push(0, 10'h3C0, 1'b0, 32'hFFFF_FFC0);
    wait_all("t6_done", 100);
    chk("t6_tie_owner", 32'(own_log[own_log.size()-2]), 32'd0);

    // counter wrap: preload near the top, then complete three transactions
    @(negedge clk);
    @(posedge clk); #1;
    force dut.done_count_q = 16'hFFFD;
    m_cnt = 16'hFFFD;
    @(posedge clk); #1;
    release dut.done_count_q;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(i % 2, 10'(i * 77), 1'b0, ref_ext(10'(i * 77), 1'b0));
    wait_all("t7_done", 100);
    @(negedge clk);
    chk("t7_wrap", 32'(done_count), 32'h0000_0000);

    // randomized traffic: gaps, withdrawals, random backpressure
    gaps_en = 1'b1; wd_en = 1'b1; rr_mode0 = 2; rr_mode1 = 2;
    for (int i = 0; i < 150; i++) begin
      logic [9:0] a, b;
      logic       za, zb;
      a = 10'($urandom); za = 1'($urandom_range(0, 1));
      b = 10'($urandom); zb = 1'($urandom_range(0, 1));
      push(0, a, za, ref_ext(a, za));
      push(1, b, zb, ref_ext(b, zb));
    end
    wait_all("t8_done", 8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
